// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - bank of independent JK register bits with change flags; optional change counter under JK_CHG_CNT_EN
module jk_reg_bank #(
    parameter int              WIDTH   = 8,
    parameter int              CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg,
`ifdef JK_CHG_CNT_EN
    output logic [CNT_W-1:0] chg_cnt,
`endif
    output logic             any_chg
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;

    // Next state: load wins over the JK update; the JK equation gives hold/clear/set/toggle per bit.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            q_d = (j & ~q_q) | (~k & q_q);
        end
        chg_d = q_d ^ q_q;
    end

    // State and change flags update together so chg always describes the edge that produced q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            chg_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

`ifdef JK_CHG_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // One count per changing edge regardless of how many bits moved; sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((|chg_d) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register cleared by reset alongside q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign chg_cnt = cnt_q;
`endif

    assign q       = q_q;
    assign q_n     = ~q_q;
    assign chg     = chg_q;
    assign any_chg = |chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - self-checking bench for jk_reg_bank against a per-bit truth-table model
module tb_jk_reg_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] load_data, j, k;
    logic [7:0] q, q_n, chg;
    logic       any_chg;
`ifdef JK_CHG_CNT_EN
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
    logic [7:0]  q2, q2_n, chg2;
    logic        any2;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  mq, mchg;
    int          mcnt16, mcnt2;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(8), .CNT_W(16), .RST_VAL(RV)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
        .j(j), .k(k), .q(q), .q_n(q_n), .chg(chg),
`ifdef JK_CHG_CNT_EN
        .chg_cnt(cnt16),
`endif
        .any_chg(any_chg)
    );

`ifdef JK_CHG_CNT_EN
    jk_reg_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(RV)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
        .j(j), .k(k), .q(q2), .q_n(q2_n), .chg(chg2),
        .chg_cnt(cnt2), .any_chg(any2)
    );
`endif

    // Drive one cycle of inputs, clock it, advance the reference model, then settle past the edge.
    task automatic do_edge(input logic r, input logic e, input logic l,
                           input logic [7:0] d, input logic [7:0] jj, input logic [7:0] kk);
        logic [7:0] nq;
        rst = r; en = e; load = l; load_data = d; j = jj; k = kk;
        @(posedge clk);
        if (r) begin
            mq = RV; mchg = 8'h00; mcnt16 = 0; mcnt2 = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (l) nq[i] = d[i];
                else if (!e) nq[i] = mq[i];
                else begin
                    case ({jj[i], kk[i]})
                        2'b00: nq[i] = mq[i];
                        2'b01: nq[i] = 1'b0;
                        2'b10: nq[i] = 1'b1;
                        default: nq[i] = ~mq[i];
                    endcase
                end
            end
            mchg = nq ^ mq;
            if (mchg != 8'h00) begin
                if (mcnt16 < 65535) mcnt16++;
                if (mcnt2 < 3) mcnt2++;
            end
            mq = nq;
        end
        #1;
    endtask

    task automatic test_reset();
        do_edge(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'hA5); end
        checks++; if (chg !== 8'h00) begin errors++; $display("FAIL reset_chg got=%h exp=00", chg); end
        checks++; if (any_chg !== 1'b0) begin errors++; $display("FAIL reset_any got=%b exp=0", any_chg); end
        checks++; if (q_n !== 8'h5A) begin errors++; $display("FAIL reset_qn got=%h exp=5a", q_n); end
`ifdef JK_CHG_CNT_EN
        checks++; if (cnt16 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt16); end
`endif
    endtask

    task automatic test_jk_table();
        do_edge(1'b0, 1'b0, 1'b1, 8'h0F, 8'h00, 8'h00);
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL jk_preload got=%h exp=0f", q); end
        do_edge(1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 8'h55);
        checks++; if (q !== 8'h3A) begin errors++; $display("FAIL jk_q got=%h exp=3a", q); end
        checks++; if (chg !== 8'h35) begin errors++; $display("FAIL jk_chg got=%h exp=35", chg); end
        checks++; if (any_chg !== 1'b1) begin errors++; $display("FAIL jk_any got=%b exp=1", any_chg); end
        checks++; if (q_n !== 8'hC5) begin errors++; $display("FAIL jk_qn got=%h exp=c5", q_n); end
    endtask

    task automatic test_priority();
        do_edge(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
        checks++; if (q !== 8'h3A) begin errors++; $display("FAIL gate_hold_q got=%h exp=3a", q); end
        checks++; if (chg !== 8'h00) begin errors++; $display("FAIL gate_hold_chg got=%h exp=00", chg); end
        do_edge(1'b0, 1'b1, 1'b1, 8'h3C, 8'hFF, 8'hFF);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_prio_q got=%h exp=3c", q); end
        checks++; if (chg !== 8'h06) begin errors++; $display("FAIL load_prio_chg got=%h exp=06", chg); end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_q;
        int base;
        do_edge(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        base = mcnt16;
        exp_q = 8'h00;
        for (int c = 0; c < 4; c++) begin
            do_edge(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
            exp_q = ~exp_q;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL toggle_q[%0d] got=%h exp=%h", c, q, exp_q); end
            checks++; if (chg !== 8'hFF) begin errors++; $display("FAIL toggle_chg[%0d] got=%h exp=ff", c, chg); end
        end
`ifdef JK_CHG_CNT_EN
        checks++; if (cnt16 !== 16'(base + 4)) begin errors++; $display("FAIL toggle_cnt got=%0d exp=%0d", cnt16, base + 4); end
`else
        if (mcnt16 != base + 4) $display("model count drift");
`endif
    endtask

    task automatic test_saturation();
        int exp_c;
        do_edge(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) begin
            do_edge(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
            exp_c = (c + 1 > 3) ? 3 : c + 1;
`ifdef JK_CHG_CNT_EN
            checks++; if (cnt2 !== 2'(exp_c)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", c, cnt2, exp_c); end
`else
            if (mcnt2 != exp_c) $display("model count drift");
`endif
        end
        do_edge(1'b0, 1'b1, 1'b1, mq, 8'hFF, 8'hFF);
        checks++; if (chg !== 8'h00) begin errors++; $display("FAIL same_load_chg got=%h exp=00", chg); end
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL same_load_q got=%h exp=5a", q); end
`ifdef JK_CHG_CNT_EN
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL same_load_cnt got=%0d exp=3", cnt2); end
`endif
    endtask

    task automatic test_midrun_reset();
        do_edge(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
        do_edge(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
        checks++; if (q !== RV) begin errors++; $display("FAIL midrst_q got=%h exp=%h", q, RV); end
        checks++; if (chg !== 8'h00) begin errors++; $display("FAIL midrst_chg got=%h exp=00", chg); end
`ifdef JK_CHG_CNT_EN
        checks++; if (cnt16 !== 16'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", cnt16); end
`endif
        do_edge(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL resume_q got=%h exp=5a", q); end
        checks++; if (chg !== 8'hFF) begin errors++; $display("FAIL resume_chg got=%h exp=ff", chg); end
`ifdef JK_CHG_CNT_EN
        checks++; if (cnt16 !== 16'd1) begin errors++; $display("FAIL resume_cnt got=%0d exp=1", cnt16); end
`endif
    endtask

    task automatic test_random();
        logic r, e, l;
        for (int c = 0; c < 300; c++) begin
            r = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 3) == 0);
            e = $urandom_range(0, 1) == 1;
            do_edge(r, e, l, 8'($urandom), 8'($urandom), 8'($urandom));
            checks++; if (q !== mq) begin errors++; $display("FAIL rand_q[%0d] got=%h exp=%h", c, q, mq); end
            checks++; if (chg !== mchg) begin errors++; $display("FAIL rand_chg[%0d] got=%h exp=%h", c, chg, mchg); end
            checks++; if (any_chg !== (mchg != 8'h00)) begin errors++; $display("FAIL rand_any[%0d] got=%b exp=%b", c, any_chg, (mchg != 8'h00)); end
            checks++; if (q_n !== ~mq) begin errors++; $display("FAIL rand_qn[%0d] got=%h exp=%h", c, q_n, ~mq); end
`ifdef JK_CHG_CNT_EN
            checks++; if (cnt16 !== 16'(mcnt16)) begin errors++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", c, cnt16, mcnt16); end
            checks++; if (cnt2 !== 2'(mcnt2)) begin errors++; $display("FAIL rand_cnt2[%0d] got=%0d exp=%0d", c, cnt2, mcnt2); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_data = 8'h00; j = 8'h00; k = 8'h00;
        mq = RV; mchg = 8'h00; mcnt16 = 0; mcnt2 = 0;
        test_reset();
        test_jk_table();
        test_priority();
        test_toggle();
        test_saturation();
        test_midrun_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
